instruction_fetch_controller: RTL and testbench
===============================================

// Module: instruction_fetch_controller
// PURPOSE
//   Sequences the word-addressed, combinational-read instruction_memory: owns the PC and drives its address.
//   Registers each fetched word into a one-entry output buffer with a valid/ready handshake toward decode.
//   Handles branch redirect/flush, halt-opcode detection and out-of-range PC faults.
//   Sits between instruction_memory and the decode stage of the KGPMini RISC core.
// PARAMETERS
//   RESET_PC     32'd0      PC loaded on reset (word address)
//   MEM_WORDS    256        number of valid instruction words; legal PC range 0..MEM_WORDS-1
//   HALT_OPCODE  6'b111111  value of inst[31:26] that marks a halt instruction
// PORTS
//   clk         in   1   system clock, all state updates on rising edge
//   rst         in   1   synchronous reset, active-low (rst==0 at a rising edge resets)
//   start       in   1   begin fetching; honoured only in IDLE
//   imem_addr   out  32  word address to instruction_memory; equals current PC combinationally
//   imem_data   in   32  instruction word returned combinationally for imem_addr
//   br_taken    in   1   redirect request from execute; honoured only in RUN
//   br_target   in   32  redirect word address, sampled when br_taken=1
//   inst_out    out  32  buffered instruction to decode
//   pc_out      out  32  word address of inst_out
//   inst_valid  out  1   inst_out/pc_out hold a valid instruction
//   inst_ready  in   1   decode accepts inst_out this cycle (transfer = inst_valid & inst_ready)
//   halted      out  1   halt instruction captured; fetch stopped
//   fault       out  1   PC left legal range; fetch stopped (sticky)
// BEHAVIOUR
//   Reset: pc=RESET_PC, state=IDLE, inst_out=0, pc_out=0, inst_valid=0, halted=0, fault=0.
//   Reset has priority over every other input, in every state.
//   States:
//     IDLE  -> RUN on start=1 (start ignored in all other states)
//     RUN   -> HALT on halt capture; -> FAULT on range error
//     HALT  terminal until reset
//     FAULT terminal until reset
//   Capture slot: in RUN, when buffer is free: inst_valid=0, or transfer this cycle.
//   Capture action, at the edge:
//     inst_out<=imem_data; pc_out<=pc; inst_valid<=1; pc<=pc+1
//   Priority in RUN, per edge:
//     1) br_taken=1: inst_valid<=0 (flush, even if transfer occurs); pc<=br_target; no capture
//     2) pc>=MEM_WORDS at capture slot: no capture; ->FAULT; fault<=1; inst_valid<=0 only if transferred
//     3) capture slot: capture; if imem_data[31:26]==HALT_OPCODE -> HALT, halted<=1
//     4) else hold: inst_out, pc_out, inst_valid, pc unchanged (stall)
//   Latency:
//     start sampled at edge N => RUN after N; first capture at edge N+1 (inst_valid=1 after N+1)
//     Redirect costs one bubble: capture from br_target occurs the edge after the redirect edge.
//     Back-to-back: with inst_ready held 1, one instruction per cycle.
//   HALT/FAULT: the buffered word stays valid until transferred, then inst_valid<=0; pc frozen.
//   Wrap: pc=MEM_WORDS-1 captured normally; pc becomes MEM_WORDS; next capture slot faults.
//     No modular wrap. PC arithmetic is 32-bit unsigned.
//   Out-of-range br_target is accepted; the fault is raised at the following capture slot.
//   Output stability: while inst_valid=1 and inst_ready=0, inst_out/pc_out are held stable.
//   Reset mid-operation: all outputs return to reset values at that edge; start is needed again.
// TESTING
//   T1: reset, start@c0, inst_ready=1, imem words 0..3 -> inst_valid from c1; pc_out 0,1,2,3 on successive cycles
//   T2: inst_ready=0 for 3 cycles after first capture -> inst_out/pc_out=0 held; pc stays 1; then 1,2 resume
//   T3: br_taken=1, br_target=40 while pc_out=2 valid -> inst_valid=0 next cycle; following cycle pc_out=40
//   T4: word 5 = 0xFC000000 (HALT) -> captured with pc_out=5; halted=1; after transfer inst_valid=0; pc frozen at 6
//   T5: MEM_WORDS=8, run through pc 7 -> pc_out 7 delivered; fault=1, no further valid; start ignored
//   T6: rst=0 for one edge mid-RUN with inst_valid=1 -> all outputs zero; state IDLE; restart from RESET_PC

Source files
------------

// File: rtl/instruction_fetch_controller_if.sv
// Fetch-side bus bundle: instruction memory port, branch redirect and decode handshake.
// The master modport is the fetch controller; the slave modport is the surrounding core/bench.
interface instruction_fetch_controller_if;
    logic        start;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic        inst_valid;
    logic        inst_ready;
    logic        halted;
    logic        fault;

    modport master (
        input  start, imem_data, br_taken, br_target, inst_ready,
        output imem_addr, inst_out, pc_out, inst_valid, halted, fault
    );

    modport slave (
        output start, imem_data, br_taken, br_target, inst_ready,
        input  imem_addr, inst_out, pc_out, inst_valid, halted, fault
    );
endinterface

// File: rtl/instruction_fetch_controller.sv
// KGPMini fetch stage: owns the PC, reads the combinational instruction memory and
// buffers one instruction toward decode; handles redirects, halt opcodes and PC range faults.
module instruction_fetch_controller #(
    parameter logic [31:0] RESET_PC    = 32'd0,
    parameter logic [31:0] MEM_WORDS   = 32'd256,
    parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
    input  logic                                  clk,
    input  logic                                  rst,
    instruction_fetch_controller_if.master        bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] inst_q;
    logic [31:0] pc_q;
    logic        valid_q;
    logic        halted_q;
    logic        fault_q;

    logic        transfer;
    logic        slot;
    logic        pc_oob;

    assign transfer = valid_q & bus.inst_ready;
    // The buffer can take a new word when it is empty or being drained this cycle.
    assign slot     = (state == RUN) && (!valid_q || transfer);
    assign pc_oob   = (pc >= MEM_WORDS);

    assign bus.imem_addr  = pc;
    assign bus.inst_out   = inst_q;
    assign bus.pc_out     = pc_q;
    assign bus.inst_valid = valid_q;
    assign bus.halted     = halted_q;
    assign bus.fault      = fault_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            inst_q   <= 32'd0;
            pc_q     <= 32'd0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (bus.br_taken) begin
                        // Flush wins over a same-cycle transfer; target is range-checked at the next slot.
                        valid_q <= 1'b0;
                        pc      <= bus.br_target;
                    end else if (slot && pc_oob) begin
                        state   <= FAULT;
                        fault_q <= 1'b1;
                        valid_q <= 1'b0;
                    end else if (slot) begin
                        inst_q  <= bus.imem_data;
                        pc_q    <= pc;
                        valid_q <= 1'b1;
                        pc      <= pc + 32'd1;
                        if (bus.imem_data[31:26] == HALT_OPCODE) begin
                            state    <= HALT;
                            halted_q <= 1'b1;
                        end
                    end
                end
                HALT, FAULT: begin
                    // Terminal: let decode drain the last word, PC stays frozen.
                    if (transfer) begin
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Scoreboard bench for instruction_fetch_controller: a 256-word instance and an 8-word
// instance (range fault) share clock and reset; each delivered word is checked against a queue.
module tb_instruction_fetch_controller;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic clk;
    logic rst;

    int tests_run;
    int tests_failed;

    exp_t qa[$];
    exp_t qb[$];

    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];

    instruction_fetch_controller_if ifa ();
    instruction_fetch_controller_if ifb ();

    instruction_fetch_controller #(
        .RESET_PC    (32'd0),
        .MEM_WORDS   (32'd256),
        .HALT_OPCODE (6'b111111)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    instruction_fetch_controller #(
        .RESET_PC    (32'd0),
        .MEM_WORDS   (32'd8),
        .HALT_OPCODE (6'b111111)
    ) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    assign ifa.imem_data = (ifa.imem_addr < 32'd256) ? mem_a[ifa.imem_addr[7:0]] : 32'hDEAD_BEEF;
    assign ifb.imem_data = (ifb.imem_addr < 32'd256) ? mem_b[ifb.imem_addr[7:0]] : 32'hDEAD_BEEF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // Scoreboard monitors: a transfer at the coming edge is visible at the negedge before it.
    always @(negedge clk) begin
        if (rst && ifa.inst_valid && ifa.inst_ready) begin
            tests_run++;
            if (qa.size() == 0) begin
                tests_failed++;
                $display("FAIL sb_a_unexpected: got pc %0d inst %h, required no transfer", ifa.pc_out, ifa.inst_out);
            end else begin
                exp_t e;
                e = qa.pop_front();
                if (ifa.pc_out !== e.pc || ifa.inst_out !== e.inst) begin
                    tests_failed++;
                    $display("FAIL sb_a_word: got pc %0d inst %h, required pc %0d inst %h",
                             ifa.pc_out, ifa.inst_out, e.pc, e.inst);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst && ifb.inst_valid && ifb.inst_ready) begin
            tests_run++;
            if (qb.size() == 0) begin
                tests_failed++;
                $display("FAIL sb_b_unexpected: got pc %0d inst %h, required no transfer", ifb.pc_out, ifb.inst_out);
            end else begin
                exp_t e;
                e = qb.pop_front();
                if (ifb.pc_out !== e.pc || ifb.inst_out !== e.inst) begin
                    tests_failed++;
                    $display("FAIL sb_b_word: got pc %0d inst %h, required pc %0d inst %h",
                             ifb.pc_out, ifb.inst_out, e.pc, e.inst);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [31:0] pc);
        exp_t e;
        e.pc   = pc;
        e.inst = mem_a[pc[7:0]];
        qa.push_back(e);
    endtask

    task automatic push_b(input logic [31:0] pc);
        exp_t e;
        e.pc   = pc;
        e.inst = mem_b[pc[7:0]];
        qb.push_back(e);
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        ifa.start = 1'b0; ifa.br_taken = 1'b0; ifa.br_target = 32'd0; ifa.inst_ready = 1'b0;
        ifb.start = 1'b0; ifb.br_taken = 1'b0; ifb.br_target = 32'd0; ifb.inst_ready = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        tests_run++;
        if (ifa.inst_valid !== 1'b0 || ifa.halted !== 1'b0 || ifa.fault !== 1'b0 ||
            ifa.inst_out !== 32'd0 || ifa.pc_out !== 32'd0 || ifa.imem_addr !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got v%b h%b f%b inst %h pc %0d addr %0d, required all zero",
                     ifa.inst_valid, ifa.halted, ifa.fault, ifa.inst_out, ifa.pc_out, ifa.imem_addr);
        end
        // Without start the controller must stay idle.
        ifa.inst_ready = 1'b1;
        tick();
        tick();
        tests_run++;
        if (ifa.inst_valid !== 1'b0 || ifa.imem_addr !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_idle: got valid %b addr %0d, required valid 0 addr 0", ifa.inst_valid, ifa.imem_addr);
        end
    endtask

    task automatic test_stream();
        apply_reset();
        for (int i = 0; i < 4; i++) push_a(i);
        ifa.inst_ready = 1'b1;
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        tests_run++;
        if (ifa.inst_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL stream_latency: got valid %b after start edge, required 0", ifa.inst_valid);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++;
            if (ifa.inst_valid !== 1'b1 || ifa.pc_out !== 32'(i)) begin
                tests_failed++;
                $display("FAIL stream_pc: got valid %b pc %0d, required valid 1 pc %0d", ifa.inst_valid, ifa.pc_out, i);
            end
        end
        tick();
        ifa.inst_ready = 1'b0;
        tests_run++;
        if (qa.size() != 0) begin
            tests_failed++;
            $display("FAIL stream_drain: got %0d pending, required 0", qa.size());
        end
    endtask

    task automatic test_stall();
        apply_reset();
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (ifa.inst_valid !== 1'b1 || ifa.pc_out !== 32'd0 ||
                ifa.inst_out !== mem_a[0] || ifa.imem_addr !== 32'd1) begin
                tests_failed++;
                $display("FAIL stall_hold: got valid %b pc %0d inst %h addr %0d, required 1 0 %h 1",
                         ifa.inst_valid, ifa.pc_out, ifa.inst_out, ifa.imem_addr, mem_a[0]);
            end
        end
        push_a(0); push_a(1); push_a(2);
        ifa.inst_ready = 1'b1;
        for (int i = 1; i < 3; i++) begin
            tick();
            tests_run++;
            if (ifa.pc_out !== 32'(i)) begin
                tests_failed++;
                $display("FAIL stall_resume: got pc %0d, required %0d", ifa.pc_out, i);
            end
        end
        tick();
        ifa.inst_ready = 1'b0;
        tests_run++;
        if (qa.size() != 0) begin
            tests_failed++;
            $display("FAIL stall_drain: got %0d pending, required 0", qa.size());
        end
    endtask

    task automatic test_branch();
        apply_reset();
        push_a(0); push_a(1); push_a(2); push_a(40);
        ifa.inst_ready = 1'b1;
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        tick(); tick(); tick();
        tests_run++;
        if (ifa.pc_out !== 32'd2 || ifa.inst_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL branch_pre: got pc %0d valid %b, required pc 2 valid 1", ifa.pc_out, ifa.inst_valid);
        end
        ifa.br_taken = 1'b1;
        ifa.br_target = 32'd40;
        tick();
        ifa.br_taken = 1'b0;
        tests_run++;
        if (ifa.inst_valid !== 1'b0 || ifa.imem_addr !== 32'd40) begin
            tests_failed++;
            $display("FAIL branch_bubble: got valid %b addr %0d, required valid 0 addr 40", ifa.inst_valid, ifa.imem_addr);
        end
        tick();
        tests_run++;
        if (ifa.inst_valid !== 1'b1 || ifa.pc_out !== 32'd40 || ifa.inst_out !== mem_a[40]) begin
            tests_failed++;
            $display("FAIL branch_target: got valid %b pc %0d inst %h, required 1 40 %h",
                     ifa.inst_valid, ifa.pc_out, ifa.inst_out, mem_a[40]);
        end
        tick();
        ifa.inst_ready = 1'b0;
        tests_run++;
        if (ifa.pc_out !== 32'd41 || qa.size() != 0) begin
            tests_failed++;
            $display("FAIL branch_next: got pc %0d pending %0d, required pc 41 pending 0", ifa.pc_out, qa.size());
        end
    endtask

    task automatic test_halt();
        apply_reset();
        for (int i = 0; i < 6; i++) push_a(i);
        ifa.inst_ready = 1'b1;
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        tests_run++;
        if (ifa.halted !== 1'b1 || ifa.pc_out !== 32'd5 || ifa.inst_out !== 32'hFC00_0000 || ifa.inst_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL halt_capture: got halted %b pc %0d inst %h valid %b, required 1 5 fc000000 1",
                     ifa.halted, ifa.pc_out, ifa.inst_out, ifa.inst_valid);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (ifa.inst_valid !== 1'b0 || ifa.halted !== 1'b1 || ifa.imem_addr !== 32'd6) begin
                tests_failed++;
                $display("FAIL halt_frozen: got valid %b halted %b addr %0d, required 0 1 6",
                         ifa.inst_valid, ifa.halted, ifa.imem_addr);
            end
        end
        ifa.inst_ready = 1'b0;
        tests_run++;
        if (qa.size() != 0) begin
            tests_failed++;
            $display("FAIL halt_drain: got %0d pending, required 0", qa.size());
        end
    endtask

    task automatic test_fault();
        apply_reset();
        for (int i = 0; i < 8; i++) push_b(i);
        ifb.inst_ready = 1'b1;
        ifb.start = 1'b1;
        tick();
        ifb.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            tests_run++;
            if (ifb.pc_out !== 32'(i) || ifb.fault !== 1'b0) begin
                tests_failed++;
                $display("FAIL fault_stream: got pc %0d fault %b, required pc %0d fault 0", ifb.pc_out, ifb.fault, i);
            end
        end
        tick();
        tests_run++;
        if (ifb.fault !== 1'b1 || ifb.inst_valid !== 1'b0 || ifb.imem_addr !== 32'd8) begin
            tests_failed++;
            $display("FAIL fault_raise: got fault %b valid %b addr %0d, required 1 0 8",
                     ifb.fault, ifb.inst_valid, ifb.imem_addr);
        end
        ifb.start = 1'b1;
        tick();
        tick();
        ifb.start = 1'b0;
        tests_run++;
        if (ifb.fault !== 1'b1 || ifb.inst_valid !== 1'b0 || ifb.imem_addr !== 32'd8) begin
            tests_failed++;
            $display("FAIL fault_sticky: got fault %b valid %b addr %0d, required 1 0 8",
                     ifb.fault, ifb.inst_valid, ifb.imem_addr);
        end
        ifb.inst_ready = 1'b0;
        tests_run++;
        if (qb.size() != 0) begin
            tests_failed++;
            $display("FAIL fault_drain: got %0d pending, required 0", qb.size());
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tests_run++;
        if (ifa.inst_valid !== 1'b0 || ifa.inst_out !== 32'd0 || ifa.pc_out !== 32'd0 ||
            ifa.imem_addr !== 32'd0 || ifa.halted !== 1'b0 || ifa.fault !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_outputs: got v%b inst %h pc %0d addr %0d h%b f%b, required all zero",
                     ifa.inst_valid, ifa.inst_out, ifa.pc_out, ifa.imem_addr, ifa.halted, ifa.fault);
        end
        tick();
        tests_run++;
        if (ifa.inst_valid !== 1'b0 || ifa.imem_addr !== 32'd0) begin
            tests_failed++;
            $display("FAIL midreset_idle: got valid %b addr %0d, required 0 0", ifa.inst_valid, ifa.imem_addr);
        end
        push_a(0);
        ifa.inst_ready = 1'b1;
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        tick();
        tests_run++;
        if (ifa.inst_valid !== 1'b1 || ifa.pc_out !== 32'd0) begin
            tests_failed++;
            $display("FAIL midreset_restart: got valid %b pc %0d, required 1 0", ifa.inst_valid, ifa.pc_out);
        end
        tick();
        ifa.inst_ready = 1'b0;
        tests_run++;
        if (ifa.pc_out !== 32'd1 || qa.size() != 0) begin
            tests_failed++;
            $display("FAIL midreset_next: got pc %0d pending %0d, required pc 1 pending 0", ifa.pc_out, qa.size());
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 32'h1000_0000 + 32'(i * 3);
            mem_b[i] = 32'h2000_0000 + 32'(i * 5);
        end
        mem_a[5] = 32'hFC00_0000;
        rst = 1'b1;
        ifa.start = 1'b0; ifa.br_taken = 1'b0; ifa.br_target = 32'd0; ifa.inst_ready = 1'b0;
        ifb.start = 1'b0; ifb.br_taken = 1'b0; ifb.br_target = 32'd0; ifb.inst_ready = 1'b0;
        #2;
        test_reset();
        test_stream();
        test_stall();
        test_branch();
        test_halt();
        test_fault();
        test_reset_mid();
        tick();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
